// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for uart_rx_fifo: serial input, control strobes and FIFO/status outputs.
// master = firmware/bench side, slave = receiver.
interface uart_rx_fifo_if #(
  parameter int unsigned CNT_W = 4
);
  logic             rx_i;
  logic [15:0]      clk_div_i;
  logic             rx_en_i;
  logic             rd_en_i;
  logic             err_clr_i;
  logic [7:0]       rd_data_o;
  logic             rx_valid_o;
  logic             fifo_full_o;
  logic [CNT_W-1:0] fifo_count_o;
  logic             frame_err_o;
  logic             overrun_o;
  logic             parity_err_o;

  modport master (
    output rx_i, clk_div_i, rx_en_i, rd_en_i, err_clr_i,
    input  rd_data_o, rx_valid_o, fifo_full_o, fifo_count_o,
           frame_err_o, overrun_o, parity_err_o
  );

  modport slave (
    input  rx_i, clk_div_i, rx_en_i, rd_en_i, err_clr_i,
    output rd_data_o, rx_valid_o, fifo_full_o, fifo_count_o,
           frame_err_o, overrun_o, parity_err_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a first-word-fall-through byte FIFO with sticky errors.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  uart_rx_fifo_if.slave  bus
);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned MIN_DIV = 4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;
`endif

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic [DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               push, set_ferr, set_perr, sample, rxs;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               valid_q, valid_d, full_q, full_d;
  logic               ferr_q, ferr_d, ovr_q, ovr_d;
  logic               pop, is_full, wr_en, set_ovr;
  logic [7:0]         mem_q [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic               par_bad_q, par_bad_d, perr_q, perr_d;
`endif

  assign rxs     = sync2_q;
  assign sample  = (cnt_q == '0);
  assign div_eff = (bus.clk_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.clk_div_i;

  // Receive FSM: next state, bit timing and deframing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    set_ferr = 1'b0;
    set_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          div_d   = div_eff;
          cnt_d   = (div_eff >> 1) - DIV_W'(1);
        end
      end
      S_START: begin
        if (!sample) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (!rxs) begin
          state_d = S_DATA;
          cnt_d   = div_q - DIV_W'(1);
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!sample) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = div_q - DIV_W'(1);
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!sample) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          par_bad_d = rxs ^ (^shift_q);
          set_perr  = par_bad_d;
          cnt_d     = div_q - DIV_W'(1);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!sample) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (rxs) begin
`ifdef UART_RX_PARITY_EN
          push = !par_bad_q;
`else
          push = 1'b1;
`endif
          state_d = S_IDLE;
        end else begin
          set_ferr = 1'b1;
          state_d  = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Disabling abandons any partial frame without touching FIFO or flags
    if (!bus.rx_en_i) begin
      state_d  = S_IDLE;
      push     = 1'b0;
      set_ferr = 1'b0;
      set_perr = 1'b0;
    end
  end

  // FIFO bookkeeping; the head register bypasses the array when the push lands on the new head
  always_comb begin
    pop      = bus.rd_en_i && (count_q != '0);
    is_full  = (count_q == CNT_W'(FIFO_DEPTH));
    wr_en    = push && (!is_full || pop);
    set_ovr  = push && is_full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
    rd_data_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];
    valid_d   = (count_d != '0);
    full_d    = (count_d == CNT_W'(FIFO_DEPTH));
    ferr_d    = bus.err_clr_i ? 1'b0 : (ferr_q | set_ferr);
    ovr_d     = bus.err_clr_i ? 1'b0 : (ovr_q | set_ovr);
`ifdef UART_RX_PARITY_EN
    perr_d    = bus.err_clr_i ? 1'b0 : (perr_q | set_perr);
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= bus.rx_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Storage array carries no reset; only entries behind valid pointers are ever read
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign bus.rd_data_o    = rd_data_q;
  assign bus.rx_valid_o   = valid_q;
  assign bus.fifo_full_o  = full_q;
  assign bus.fifo_count_o = count_q;
  assign bus.frame_err_o  = ferr_q;
  assign bus.overrun_o    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err_o = perr_q;
`else
  assign bus.parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of frames plus hand sequences for timing corners.
module tb_uart_rx_fifo;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.CNT_W(4)) bus ();
  uart_rx_fifo #(.FIFO_DEPTH(8), .CNT_W(4)) dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pop;
    logic       clr;
    int         cnt;
    logic       chk_head;
    logic [7:0] head;
    logic       ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int div);
    bus.rx_i = b;
    tick(div);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
    send_bit(1'b0, div);
    for (int i = 0; i < 8; i++) send_bit(d[i], div);
`ifdef UART_RX_PARITY_EN
    send_bit(^d, div);
`endif
    send_bit(stop, div);
    bus.rx_i = 1'b1;
    tick(4);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    send_bit(par, 16);
    send_bit(1'b1, 16);
    tick(4);
  endtask
`endif

  task automatic pop1();
    bus.rd_en_i = 1'b1;
    tick(1);
    bus.rd_en_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 1, 1'b1, 8'h11, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'h11, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 3, 1'b1, 8'h11, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 3, 1'b1, 8'hFF, 1'b0};

    rst           = 1'b1;
    bus.rx_i      = 1'b1;
    bus.clk_div_i = 16'd16;
    bus.rx_en_i   = 1'b1;
    bus.rd_en_i   = 1'b0;
    bus.err_clr_i = 1'b0;
    tick(3);
    check("rst_valid", 32'(bus.rx_valid_o), 32'd0);
    check("rst_full",  32'(bus.fifo_full_o), 32'd0);
    check("rst_count", 32'(bus.fifo_count_o), 32'd0);
    check("rst_data",  32'(bus.rd_data_o), 32'd0);
    check("rst_ferr",  32'(bus.frame_err_o), 32'd0);
    check("rst_ovr",   32'(bus.overrun_o), 32'd0);
    check("rst_perr",  32'(bus.parity_err_o), 32'd0);
    rst = 1'b0;
    tick(3);

    // 0xA5 with exact push latency: stop sample cycle ends 16*(NB-1)+11 edges after start
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 8'h00, 16);
`ifdef UART_RX_PARITY_EN
    send_bit(^(8'hA5), 16);
`endif
    bus.rx_i = 1'b1;
    tick(10);
    check("lat_valid_before", 32'(bus.rx_valid_o), 32'd0);
    tick(1);
    check("lat_valid_after", 32'(bus.rx_valid_o), 32'd1);
    check("lat_data", 32'(bus.rd_data_o), 32'hA5);
    check("lat_count", 32'(bus.fifo_count_o), 32'd1);
    tick(5);
    pop1();
    check("pop_valid", 32'(bus.rx_valid_o), 32'd0);
    check("pop_count", 32'(bus.fifo_count_o), 32'd0);

    // Short low glitch must be rejected silently
    bus.rx_i = 1'b0;
    tick(5);
    bus.rx_i = 1'b1;
    tick(30);
    check("glitch_count", 32'(bus.fifo_count_o), 32'd0);
    check("glitch_ferr", 32'(bus.frame_err_o), 32'd0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, 16);
      check($sformatf("vec%0d_count", v), 32'(bus.fifo_count_o), 32'(vecs[v].cnt));
      check($sformatf("vec%0d_valid", v), 32'(bus.rx_valid_o), 32'(vecs[v].cnt != 0));
      check($sformatf("vec%0d_ferr", v), 32'(bus.frame_err_o), 32'(vecs[v].ferr));
      if (vecs[v].chk_head)
        check($sformatf("vec%0d_head", v), 32'(bus.rd_data_o), 32'(vecs[v].head));
      if (vecs[v].pop) pop1();
      if (vecs[v].clr) begin
        bus.err_clr_i = 1'b1;
        tick(1);
        bus.err_clr_i = 1'b0;
      end
    end
    check("drain_head0", 32'(bus.rd_data_o), 32'h80);
    pop1();
    check("drain_head1", 32'(bus.rd_data_o), 32'h01);
    pop1();
    check("drain_count", 32'(bus.fifo_count_o), 32'd0);

    // Divisor below the minimum runs at 4 clocks per bit
    bus.clk_div_i = 16'd2;
    send_frame(8'hC3, 1'b1, 4);
    check("div4_count", 32'(bus.fifo_count_o), 32'd1);
    check("div4_head", 32'(bus.rd_data_o), 32'hC3);
    pop1();
    bus.clk_div_i = 16'd16;

    // Clear held through a framing error wins over the set
    bus.err_clr_i = 1'b1;
    send_frame(8'h55, 1'b0, 16);
    bus.err_clr_i = 1'b0;
    check("clr_prio_ferr", 32'(bus.frame_err_o), 32'd0);
    check("clr_prio_count", 32'(bus.fifo_count_o), 32'd0);

    // Fill, overrun, then drain in order
    for (int b = 0; b < 9; b++) begin
      send_frame(8'(b), 1'b1, 16);
      if (b == 7) begin
        check("fill_full", 32'(bus.fifo_full_o), 32'd1);
        check("fill_ovr_pre", 32'(bus.overrun_o), 32'd0);
      end
    end
    check("ovr_flag", 32'(bus.overrun_o), 32'd1);
    check("ovr_full", 32'(bus.fifo_full_o), 32'd1);
    check("ovr_count", 32'(bus.fifo_count_o), 32'd8);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("read%0d", b), 32'(bus.rd_data_o), 32'(b));
      pop1();
    end
    check("read_valid_end", 32'(bus.rx_valid_o), 32'd0);
    check("read_full_end", 32'(bus.fifo_full_o), 32'd0);
    pop1();
    check("empty_pop_count", 32'(bus.fifo_count_o), 32'd0);
    bus.err_clr_i = 1'b1;
    tick(1);
    bus.err_clr_i = 1'b0;
    check("ovr_cleared", 32'(bus.overrun_o), 32'd0);

    // Simultaneous push and pop at one entry: count holds, head becomes the new byte
    send_frame(8'h21, 1'b1, 16);
    fork
      send_frame(8'h42, 1'b1, 16);
      begin
        tick(16 * (NB - 1) + 10);
        bus.rd_en_i = 1'b1;
        tick(1);
        bus.rd_en_i = 1'b0;
      end
    join
    check("pushpop_count", 32'(bus.fifo_count_o), 32'd1);
    check("pushpop_head", 32'(bus.rd_data_o), 32'h42);
    pop1();

    // Receiver disabled mid-frame: partial 0x77 discarded, following 0x5A accepted
    fork
      send_frame(8'h77, 1'b1, 16);
      begin
        tick(70);
        bus.rx_en_i = 1'b0;
      end
    join
    bus.rx_en_i = 1'b1;
    tick(4);
    check("en_drop_count0", 32'(bus.fifo_count_o), 32'd0);
    send_frame(8'h5A, 1'b1, 16);
    check("en_count", 32'(bus.fifo_count_o), 32'd1);
    check("en_head", 32'(bus.rd_data_o), 32'h5A);
    check("en_ferr", 32'(bus.frame_err_o), 32'd0);
    pop1();

`ifdef UART_RX_PARITY_EN
    send_frame_par(8'h07, 1'b0);
    check("par_bad_flag", 32'(bus.parity_err_o), 32'd1);
    check("par_bad_count", 32'(bus.fifo_count_o), 32'd0);
    send_frame_par(8'h07, 1'b1);
    check("par_ok_count", 32'(bus.fifo_count_o), 32'd1);
    check("par_ok_head", 32'(bus.rd_data_o), 32'h07);
    bus.err_clr_i = 1'b1;
    tick(1);
    bus.err_clr_i = 1'b0;
    check("par_cleared", 32'(bus.parity_err_o), 32'd0);
`else
    check("perr_tied", 32'(bus.parity_err_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
